dcache_wt: RTL

- Direct-mapped, write-through, no-write-allocate data cache with one-word lines.
- Sits between the pipeline's memory stage and the backing data memory.
- Serves load hits in the same cycle.
- On a load miss or any store, it stalls the pipeline and runs a req/ack transaction to memory.
- Keeps saturating read hit/miss counters for performance measurement.

---
 rtl/dcache_wt_if.sv | 35 +++
 rtl/dcache_wt.sv | 130 +++++++++++++
 2 files changed

// File: rtl/dcache_wt_if.sv
// Pipeline-side and memory-side signals of the write-through data cache.
// The master modport is the pipeline/memory environment; the slave modport is the cache.
interface dcache_wt_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
);
  logic                  re_i;
  logic                  we_i;
  logic [ADDR_WIDTH-1:0] addr_i;
  logic [DATA_WIDTH-1:0] wdata_i;
  logic                  invalidate_i;
  logic [DATA_WIDTH-1:0] rdata_o;
  logic                  stall_o;
  logic                  mem_req_o;
  logic                  mem_we_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic [DATA_WIDTH-1:0] mem_rdata_i;
  logic                  mem_ack_i;
  logic [CNT_WIDTH-1:0]  hit_count_o;
  logic [CNT_WIDTH-1:0]  miss_count_o;

  modport master (
    output re_i, we_i, addr_i, wdata_i, invalidate_i, mem_rdata_i, mem_ack_i,
    input  rdata_o, stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
           hit_count_o, miss_count_o
  );

  modport slave (
    input  re_i, we_i, addr_i, wdata_i, invalidate_i, mem_rdata_i, mem_ack_i,
    output rdata_o, stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
           hit_count_o, miss_count_o
  );
endinterface

// File: rtl/dcache_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache with one-word lines.
// Load hits return in the same cycle; load misses and all stores stall for a memory handshake.
module dcache_wt #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned INDEX_BITS = 3,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input logic        clk_i,
  input logic        rst_i,
  dcache_wt_if.slave bus
);
  localparam int unsigned Lines   = 1 << INDEX_BITS;
  localparam int unsigned TagBits = ADDR_WIDTH - INDEX_BITS - 2;

  typedef enum logic [1:0] {StIdle, StFill, StWrite} state_e;

  state_e                state_q;
  logic [Lines-1:0]      valid_q;
  logic [TagBits-1:0]    tag_q  [Lines];
  logic [DATA_WIDTH-1:0] data_q [Lines];
  logic [CNT_WIDTH-1:0]  hit_cnt_q;
  logic [CNT_WIDTH-1:0]  miss_cnt_q;
  logic                  mem_req_q;
  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;

  logic [INDEX_BITS-1:0] req_idx;
  logic [INDEX_BITS-1:0] fill_idx;
  logic [TagBits-1:0]    req_tag;
  logic [TagBits-1:0]    fill_tag;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic                  hit;
  logic                  stall;
  logic [DATA_WIDTH-1:0] rdata;

  assign req_idx   = bus.addr_i[INDEX_BITS+1:2];
  assign req_tag   = bus.addr_i[ADDR_WIDTH-1:INDEX_BITS+2];
  assign word_addr = bus.addr_i & ~ADDR_WIDTH'(3);
  assign hit       = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  // Fills use the latched request address, never the live pipeline address.
  assign fill_idx  = mem_addr_q[INDEX_BITS+1:2];
  assign fill_tag  = mem_addr_q[ADDR_WIDTH-1:INDEX_BITS+2];

  always_comb begin
    stall = 1'b0;
    rdata = '0;
    unique case (state_q)
      StIdle: begin
        if (bus.we_i) begin
          stall = 1'b1;
        end else if (bus.re_i) begin
          if (hit) rdata = data_q[req_idx];
          else     stall = 1'b1;
        end
      end
      StFill: begin
        if (bus.mem_ack_i) rdata = bus.mem_rdata_i;
        else               stall = 1'b1;
      end
      StWrite: stall = !bus.mem_ack_i;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= StIdle;
      valid_q     <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.we_i) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= word_addr;
            mem_wdata_q <= bus.wdata_i;
            if (hit) data_q[req_idx] <= bus.wdata_i;
            state_q     <= StWrite;
          end else if (bus.re_i) begin
            if (hit) begin
              if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + CNT_WIDTH'(1);
            end else begin
              mem_req_q  <= 1'b1;
              mem_we_q   <= 1'b0;
              mem_addr_q <= word_addr;
              if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + CNT_WIDTH'(1);
              state_q    <= StFill;
            end
          end else if (bus.invalidate_i) begin
            valid_q <= '0;
          end
        end
        StFill: begin
          if (bus.mem_ack_i) begin
            data_q[fill_idx]  <= bus.mem_rdata_i;
            tag_q[fill_idx]   <= fill_tag;
            valid_q[fill_idx] <= 1'b1;
            mem_req_q         <= 1'b0;
            state_q           <= StIdle;
          end
        end
        StWrite: begin
          if (bus.mem_ack_i) begin
            mem_req_q <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.rdata_o      = rdata;
  assign bus.stall_o      = stall;
  assign bus.mem_req_o    = mem_req_q;
  assign bus.mem_we_o     = mem_we_q;
  assign bus.mem_addr_o   = mem_addr_q;
  assign bus.mem_wdata_o  = mem_wdata_q;
  assign bus.hit_count_o  = hit_cnt_q;
  assign bus.miss_count_o = miss_cnt_q;
endmodule
